// File: rtl/arb_pkg.sv
// Shared cache/memory arbiter types: FSM state encoding, grant identity and
// default bus widths used by cache_mem_arbiter and its helpers.
package arb_pkg;

   localparam int unsigned ARB_MEM_AW = 23;
   localparam int unsigned ARB_DW     = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SERVE_I,
      ST_SERVE_D,
      ST_RESP
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Memory-side request/response bundle between the cache arbiter (master)
// and the backing memory (slave).
interface cache_mem_arbiter_if
   import arb_pkg::*;
#(
   parameter int unsigned MEM_AW = ARB_MEM_AW,
   parameter int unsigned DW     = ARB_DW
) ();

   logic              req;
   logic              we;
   logic [MEM_AW-1:0] addr;
   logic [DW-1:0]     wdata;
   logic              done;
   logic [DW-1:0]     rdata;

   modport master (output req, we, addr, wdata, input done, rdata);
   modport slave  (input req, we, addr, wdata, output done, rdata);

endinterface

// File: rtl/rr_arb2.sv
// Two-way requester arbiter: combinational grant plus the last_grant register.
// Define DCACHE_PRIORITY_EN to make D win every simultaneous contest.
module rr_arb2
   import arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   req_i,
   input  logic   req_d,
   input  logic   update,
   input  grant_t upd_grant,
   output logic   gnt_valid,
   output grant_t gnt
);

   grant_t last_grant;

   // Reset to D so the I-cache wins the first simultaneous contest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= GNT_D;
      else if (update)
         last_grant <= upd_grant;
   end

   always_comb begin
      gnt_valid = req_i | req_d;
      gnt       = GNT_I;
      if (req_i && req_d) begin
`ifdef DCACHE_PRIORITY_EN
         gnt = GNT_D;
`else
         gnt = (last_grant == GNT_D) ? GNT_I : GNT_D;
`endif
      end else if (req_d) begin
         gnt = GNT_D;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/write-backs onto one memory port.
// Build option: DCACHE_PRIORITY_EN (D always wins simultaneous requests).
module cache_mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned MEM_AW = ARB_MEM_AW,
   parameter int unsigned DW     = ARB_DW
) (
   input  logic              i_riscv_clk,
   input  logic              i_riscv_rst_n,
   input  logic              i_ic_req,
   input  logic [MEM_AW-1:0] i_ic_addr,
   output logic              o_ic_done,
   output logic [DW-1:0]     o_ic_rdata,
   input  logic              i_dc_req,
   input  logic              i_dc_we,
   input  logic [MEM_AW-1:0] i_dc_addr,
   input  logic [DW-1:0]     i_dc_wdata,
   output logic              o_dc_done,
   output logic [DW-1:0]     o_dc_rdata,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic [DW-1:0]     o_mem_wdata,
   input  logic              i_mem_done,
   input  logic [DW-1:0]     i_mem_rdata,
   output logic              o_busy
);

   arb_state_t        state, state_nxt;
   grant_t            granted, gnt;
   logic              gnt_valid;
   logic              arb_update;
   logic              lat_we;
   logic [MEM_AW-1:0] lat_addr;
   logic [DW-1:0]     lat_wdata;

   cache_mem_arbiter_if #(.MEM_AW(MEM_AW), .DW(DW)) mem_bus ();

   rr_arb2 u_rr_arb2 (
      .clk       (i_riscv_clk),
      .rst_n     (i_riscv_rst_n),
      .req_i     (i_ic_req),
      .req_d     (i_dc_req),
      .update    (arb_update),
      .upd_grant (granted),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
      if (!i_riscv_rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      arb_update = 1'b0;
      case (state)
         ST_IDLE: begin
            if (gnt_valid)
               state_nxt = (gnt == GNT_I) ? ST_SERVE_I : ST_SERVE_D;
         end
         ST_SERVE_I, ST_SERVE_D: begin
            if (mem_bus.done) begin
               state_nxt  = ST_RESP;
               arb_update = 1'b1;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request fields are captured at grant so a requester dropping its
   // request mid-transaction cannot disturb the memory access.
   always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
      if (!i_riscv_rst_n) begin
         granted    <= GNT_D;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         o_ic_rdata <= '0;
         o_dc_rdata <= '0;
      end else begin
         if (state == ST_IDLE && gnt_valid) begin
            granted   <= gnt;
            lat_we    <= (gnt == GNT_D) ? i_dc_we : 1'b0;
            lat_addr  <= (gnt == GNT_D) ? i_dc_addr : i_ic_addr;
            lat_wdata <= (gnt == GNT_D) ? i_dc_wdata : '0;
         end
         if (state == ST_SERVE_I && mem_bus.done)
            o_ic_rdata <= mem_bus.rdata;
         if (state == ST_SERVE_D && mem_bus.done && !lat_we)
            o_dc_rdata <= mem_bus.rdata;
      end
   end

   assign mem_bus.req   = (state == ST_SERVE_I) || (state == ST_SERVE_D);
   assign mem_bus.we    = mem_bus.req & lat_we;
   assign mem_bus.addr  = mem_bus.req ? lat_addr : '0;
   assign mem_bus.wdata = mem_bus.req ? lat_wdata : '0;
   assign mem_bus.done  = i_mem_done;
   assign mem_bus.rdata = i_mem_rdata;

   assign o_mem_req   = mem_bus.req;
   assign o_mem_we    = mem_bus.we;
   assign o_mem_addr  = mem_bus.addr;
   assign o_mem_wdata = mem_bus.wdata;

   assign o_ic_done = (state == ST_RESP) && (granted == GNT_I);
   assign o_dc_done = (state == ST_RESP) && (granted == GNT_D);
   assign o_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed plus randomized bench for cache_mem_arbiter; a transaction-level
// model predicts grant order, memory-side fields and returned data.
module tb_cache_mem_arbiter;

   localparam int unsigned AW = 23;
   localparam int unsigned DW = 128;

   logic          clk;
   logic          rst_n;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic          ic_done;
   logic [DW-1:0] ic_rdata;
   logic          dc_req;
   logic          dc_we;
   logic [AW-1:0] dc_addr;
   logic [DW-1:0] dc_wdata;
   logic          dc_done;
   logic [DW-1:0] dc_rdata;
   logic          busy;

   cache_mem_arbiter_if #(.MEM_AW(AW), .DW(DW)) mem_if ();

   cache_mem_arbiter #(.MEM_AW(AW), .DW(DW)) dut (
      .i_riscv_clk   (clk),
      .i_riscv_rst_n (rst_n),
      .i_ic_req      (ic_req),
      .i_ic_addr     (ic_addr),
      .o_ic_done     (ic_done),
      .o_ic_rdata    (ic_rdata),
      .i_dc_req      (dc_req),
      .i_dc_we       (dc_we),
      .i_dc_addr     (dc_addr),
      .i_dc_wdata    (dc_wdata),
      .o_dc_done     (dc_done),
      .o_dc_rdata    (dc_rdata),
      .o_mem_req     (mem_if.req),
      .o_mem_we      (mem_if.we),
      .o_mem_addr    (mem_if.addr),
      .o_mem_wdata   (mem_if.wdata),
      .i_mem_done    (mem_if.done),
      .i_mem_rdata   (mem_if.rdata),
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model state: who was served last and what each cache holds.
   bit            ref_last_d;
   logic [DW-1:0] ref_ic_rdata;
   logic [DW-1:0] ref_dc_rdata;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] rand_block();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      ref_last_d   = 1'b1;
      ref_ic_rdata = '0;
      ref_dc_rdata = '0;
   endtask

   function automatic bit predict_d_wins();
      if (ic_req && dc_req) begin
`ifdef DCACHE_PRIORITY_EN
         return 1'b1;
`else
         return !ref_last_d;
`endif
      end
      return dc_req;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, DW'(busy), '0);
      chk({tag, "_icdone"}, DW'(ic_done), '0);
      chk({tag, "_dcdone"}, DW'(dc_done), '0);
      chk({tag, "_memreq"}, DW'(mem_if.req), '0);
      chk({tag, "_memwe"}, DW'(mem_if.we), '0);
      chk({tag, "_memaddr"}, DW'(mem_if.addr), '0);
      chk({tag, "_memwdata"}, mem_if.wdata, '0);
      chk({tag, "_icrdata"}, ic_rdata, '0);
      chk({tag, "_dcrdata"}, dc_rdata, '0);
   endtask

   // Called at an IDLE-cycle negedge with the requests already applied.
   task automatic serve(input bit win_d, input int unsigned waits, input logic [DW-1:0] rd);
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      logic          ewe;
      ea  = win_d ? dc_addr : ic_addr;
      ewe = win_d ? dc_we : 1'b0;
      ew  = win_d ? dc_wdata : '0;
      @(negedge clk);
      chk("serve_req", DW'(mem_if.req), DW'(1'b1));
      chk("serve_busy", DW'(busy), DW'(1'b1));
      chk("serve_addr", DW'(mem_if.addr), DW'(ea));
      chk("serve_we", DW'(mem_if.we), DW'(ewe));
      chk("serve_wdata", mem_if.wdata, ew);
      for (int i = 0; i < int'(waits); i++) begin
         @(negedge clk);
         chk("wait_req", DW'(mem_if.req), DW'(1'b1));
         chk("wait_nodone", DW'({ic_done, dc_done}), '0);
      end
      mem_if.done  = 1'b1;
      mem_if.rdata = rd;
      @(negedge clk);
      mem_if.done  = 1'b0;
      mem_if.rdata = rand_block();
      if (!win_d)    ref_ic_rdata = rd;
      else if (!ewe) ref_dc_rdata = rd;
      ref_last_d = win_d;
      chk("resp_icdone", DW'(ic_done), DW'(!win_d));
      chk("resp_dcdone", DW'(dc_done), DW'(win_d));
      chk("resp_memreq", DW'(mem_if.req), '0);
      chk("resp_memaddr", DW'(mem_if.addr), '0);
      chk("resp_memwdata", mem_if.wdata, '0);
      chk("resp_icrdata", ic_rdata, ref_ic_rdata);
      chk("resp_dcrdata", dc_rdata, ref_dc_rdata);
      if (win_d) dc_req = 1'b0;
      else       ic_req = 1'b0;
      @(negedge clk);
      chk("idle_busy", DW'(busy), '0);
      chk("idle_done", DW'({ic_done, dc_done}), '0);
   endtask

   task automatic contest(input int unsigned waits);
      bit first_d;
      first_d = predict_d_wins();
      serve(first_d, waits, rand_block());
      if (ic_req || dc_req)
         serve(predict_d_wins(), $urandom_range(0, 3), rand_block());
   endtask

   initial begin
      logic [DW-1:0] held;
      ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
      mem_if.done = 0; mem_if.rdata = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single I refill, three memory wait cycles.
      ic_req = 1; ic_addr = 23'h000100;
      serve(1'b0, 3, {16{8'hA5}});
      chk("ic_rdata_a5", ic_rdata, {16{8'hA5}});

      // Simultaneous contests; the second should go the other way round-robin.
      model_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ic_req = 1; ic_addr = 23'h012345;
      dc_req = 1; dc_we = 0; dc_addr = 23'h054321; dc_wdata = rand_block();
      contest(1);
      ic_req = 1; dc_req = 1;
      contest(0);

      // D write-back at the top block address.
      held = dc_rdata;
      dc_req = 1; dc_we = 1; dc_addr = 23'h7FFFFF;
      dc_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      serve(1'b1, 1, rand_block());
      chk("wb_dcrdata_kept", dc_rdata, held);
      dc_we = 0;

      // Stray memory completion while idle.
      mem_if.done = 1; mem_if.rdata = rand_block();
      @(negedge clk);
      mem_if.done = 0;
      @(negedge clk);
      chk("stray_busy", DW'(busy), '0);
      chk("stray_done", DW'({ic_done, dc_done}), '0);
      chk("stray_icrdata", ic_rdata, ref_ic_rdata);
      chk("stray_dcrdata", dc_rdata, ref_dc_rdata);

      // Reset in the middle of a D refill; the late completion must vanish.
      dc_req = 1; dc_addr = 23'h00ABCD;
      @(negedge clk);
      chk("mid_serve_d", DW'(mem_if.addr), DW'(dc_addr));
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all_zero("midrst");
      dc_req = 0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_if.done = 1; mem_if.rdata = rand_block();
      @(negedge clk);
      mem_if.done = 0;
      check_all_zero("late_done");
      ic_req = 1; ic_addr = 23'h000200;
      serve(1'b0, 0, rand_block());

      // Randomized traffic against the model.
      for (int n = 0; n < 40; n++) begin
         int unsigned pick;
         pick    = $urandom_range(1, 3);
         ic_req  = pick[0];
         dc_req  = pick[1];
         ic_addr = AW'($urandom());
         dc_addr = AW'($urandom());
         dc_we   = 1'($urandom());
         dc_wdata = rand_block();
         contest($urandom_range(0, 4));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
